// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage pipelined register-file datapath with FU, const/load muxes,
// registered flags and a one-entry writeback stage.
// Parameters:
//   WIDTH  data width (default 8)
//   RA_W   register address width; the file holds 2^(RA_W+1) registers (default 3)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid             issue the control word this cycle
//   DA/AA/BA, TD/TA/TB   destination / A / B register addresses and bank bits
//   RW, MB, MD, FS       write enable, B-const select, load select, function select
//   const_in, data_in    constant operand and load data
//   A_data, B_data       operands read this cycle (after bypass), combinational
//   result, V/C/N/Z      registered D value and flags of the last issued word
//   out_valid            result/flags belong to the word issued last cycle
// Define DATAPATH_BYPASS_EN to build writeback-to-read forwarding on both read ports.
module datapath_pipe #(
   parameter int WIDTH = 8,
   parameter int RA_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [RA_W-1:0]  DA,
   input  logic [RA_W-1:0]  AA,
   input  logic [RA_W-1:0]  BA,
   input  logic             TD,
   input  logic             TA,
   input  logic             TB,
   input  logic             RW,
   input  logic             MB,
   input  logic             MD,
   input  logic [3:0]       FS,
   input  logic [WIDTH-1:0] const_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] A_data,
   output logic [WIDTH-1:0] B_data,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             V,
   output logic             C,
   output logic             N,
   output logic             Z
);

   localparam int NREG = 2 ** (RA_W + 1);
   localparam int MSB  = WIDTH - 1;

   logic [WIDTH-1:0] rf [NREG];

   logic [RA_W:0]    addr_a;
   logic [RA_W:0]    addr_b;
   logic [RA_W:0]    addr_d;

   logic             wb_valid;
   logic             wb_rw;
   logic [RA_W:0]    wb_addr;
   logic [WIDTH-1:0] wb_d;

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] add_y;
   logic             add_ci;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] fu;
   logic             fu_c;
   logic             fu_v;
   logic [WIDTH-1:0] d_mux;

   assign addr_a = {TA, AA};
   assign addr_b = {TB, BA};
   assign addr_d = {TD, DA};

   // Operand read, optionally forwarding the value WB writes this cycle.
`ifdef DATAPATH_BYPASS_EN
   logic wb_wr;
   assign wb_wr  = wb_valid & wb_rw;
   assign A_data = (wb_wr && wb_addr == addr_a) ? wb_d : rf[addr_a];
   assign B_data = (wb_wr && wb_addr == addr_b) ? wb_d : rf[addr_b];
`else
   assign A_data = rf[addr_a];
   assign B_data = rf[addr_b];
`endif

   assign op_b = MB ? const_in : B_data;

   // FS 0-7 share one adder: A + y + ci.
   always_comb begin
      add_y  = '0;
      add_ci = 1'b0;
      unique case (FS[2:0])
         3'd1: add_ci = 1'b1;
         3'd2: add_y  = op_b;
         3'd3: begin
            add_y  = op_b;
            add_ci = 1'b1;
         end
         3'd4: add_y  = ~op_b;
         3'd5: begin
            add_y  = ~op_b;
            add_ci = 1'b1;
         end
         3'd6: add_y  = '1;
         default: ;
      endcase
   end

   assign sum = {1'b0, A_data} + {1'b0, add_y}
              + {{WIDTH{1'b0}}, add_ci};

   always_comb begin
      fu   = A_data;
      fu_c = 1'b0;
      fu_v = 1'b0;
      if (!FS[3]) begin
         fu   = sum[MSB:0];
         fu_c = sum[WIDTH];
         // Overflow: like-signed inputs giving an opposite-signed sum.
         fu_v = (A_data[MSB] == add_y[MSB])
              & (sum[MSB] != A_data[MSB]);
      end else begin
         unique case (FS[2:0])
            3'd0: fu = A_data & op_b;
            3'd1: fu = A_data | op_b;
            3'd2: fu = A_data ^ op_b;
            3'd3: fu = ~A_data;
            3'd5: begin
               fu   = op_b >> 1;
               fu_c = op_b[0];
            end
            3'd6: begin
               fu   = op_b << 1;
               fu_c = op_b[MSB];
            end
            default: fu = op_b;
         endcase
      end
   end

   assign d_mux = MD ? data_in : fu;

   // The WB data register doubles as the visible result.
   assign result    = wb_d;
   assign out_valid = wb_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         wb_valid <= 1'b0;
         wb_rw    <= 1'b0;
         wb_addr  <= '0;
         wb_d     <= '0;
         V        <= 1'b0;
         C        <= 1'b0;
         N        <= 1'b0;
         Z        <= 1'b0;
      end else begin
         if (wb_valid && wb_rw) rf[wb_addr] <= wb_d;
         wb_valid <= in_valid;
         if (in_valid) begin
            wb_rw   <= RW;
            wb_addr <= addr_d;
            wb_d    <= d_mux;
            V       <= fu_v;
            C       <= fu_c;
            N       <= fu[MSB];
            Z       <= (fu == '0);
         end
      end
   end

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed test-plan sequences plus random control words,
// checked against a behavioural model of registers, pending writeback and flags.
module tb_datapath_pipe;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] DA = '0, AA = '0, BA = '0;
   logic       TD = 1'b0, TA = 1'b0, TB = 1'b0;
   logic       RW = 1'b0, MB = 1'b0, MD = 1'b0;
   logic [3:0] FS = '0;
   logic [7:0] const_in = '0, data_in = '0;
   logic [7:0] A_data, B_data, result;
   logic       out_valid, V, C, N, Z;

   always #5 clk = ~clk;

   datapath_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .DA(DA), .AA(AA), .BA(BA), .TD(TD), .TA(TA), .TB(TB),
      .RW(RW), .MB(MB), .MD(MD), .FS(FS),
      .const_in(const_in), .data_in(data_in),
      .A_data(A_data), .B_data(B_data), .result(result),
      .out_valid(out_valid), .V(V), .C(C), .N(N), .Z(Z)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [7:0] m_rf [16];
   bit         p_v, p_rw;
   logic [3:0] p_a;
   logic [7:0] p_d;
   logic [3:0] m_flags;   // {V,C,N,Z}
   logic [7:0] m_res;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      p_v = 0; p_rw = 0; p_a = '0; p_d = '0;
      m_flags = '0; m_res = '0;
   endfunction

   function automatic logic [7:0] m_read(input logic [3:0] a);
`ifdef DATAPATH_BYPASS_EN
      if (p_v && p_rw && p_a == a) return p_d;
`endif
      return m_rf[a];
   endfunction

   // Function unit by plain integer arithmetic; returns {V,C,res}.
   function automatic logic [9:0] m_fu(input logic [3:0] fs,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
      int ua, uy, ci, full, sgn;
      byte sa, sy;
      logic [7:0] r;
      logic c, v;
      c = 0; v = 0; r = '0;
      if (fs < 8) begin
         ua = a;
         ci = (fs == 1 || fs == 3 || fs == 5) ? 1 : 0;
         case (fs)
            2, 3:    uy = b;
            4, 5:    uy = 255 - b;
            6:       uy = 255;
            default: uy = 0;
         endcase
         full = ua + uy + ci;
         r = full[7:0];
         c = full > 255;
         sa = a;
         sy = uy[7:0];
         sgn = int'(sa) + int'(sy) + ci;
         v = (sgn > 127) || (sgn < -128);
      end else begin
         case (fs)
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = ~a;
            13: begin r = b / 2;         c = b[0]; end
            14: begin r = (b * 2) % 256; c = b[7]; end
            default: r = b;
         endcase
      end
      return {v, c, r};
   endfunction

   task automatic do_cycle(input bit v, input bit rw, input bit mb,
                           input bit md, input logic [3:0] fs,
                           input logic [3:0] d, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] k,
                           input logic [7:0] dat);
      logic [7:0] ea, eb, bop;
      logic [9:0] f;
      in_valid = v; RW = rw; MB = mb; MD = md; FS = fs;
      {TD, DA} = d; {TA, AA} = a; {TB, BA} = b;
      const_in = k; data_in = dat;
      #1;
      ea = m_read(a);
      eb = m_read(b);
      chk("A_data", A_data, ea);
      if (!mb) chk("B_data", B_data, eb);
      bop = mb ? k : eb;
      f = m_fu(fs, ea, bop);
      @(posedge clk);
      #1;
      if (p_v && p_rw) m_rf[p_a] = p_d;
      p_v = v;
      if (v) begin
         p_rw = rw; p_a = d;
         p_d = md ? dat : f[7:0];
         m_res = p_d;
         m_flags = {f[9], f[8], f[7], f[7:0] == 8'h00};
      end
      chk("out_valid", out_valid, p_v);
      chk("result", result, m_res);
      chk("flags", {V, C, N, Z}, m_flags);
      @(negedge clk);
   endtask

   task automatic load(input logic [3:0] d, input logic [7:0] val);
      do_cycle(1, 1, 0, 1, 4'd0, d, 4'd0, 4'd0, 8'h00, val);
   endtask

   task automatic idle(input logic [3:0] a, input logic [3:0] b);
      do_cycle(0, 1, 0, 0, 4'd2, 4'd0, a, b, 8'h00, 8'hA5);
   endtask

   initial begin
      model_reset();
      #2;
      chk("rst_result", result, 8'h00);
      chk("rst_flags", {V, C, N, Z}, 4'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset during the writeback cycle discards the pending write
      load(4'd1, 8'h55);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midwb_result", result, 8'h00);
      chk("midwb_out_valid", out_valid, 1'b0);
      chk("midwb_flags", {V, C, N, Z}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4'd1, 4'd1);
      chk("midwb_r1", A_data, 8'h00);

      // 0x7F + 0x01
      load(4'd1, 8'h7F);
      load(4'd2, 8'h01);
      idle(4'd0, 4'd0);
      do_cycle(1, 1, 0, 0, 4'd2, 4'd3, 4'd1, 4'd2, 8'h00, 8'h00);
      chk("add_result", result, 8'h80);
      chk("add_flags", {V, C, N, Z}, 4'b1010);

      // 0x10 - const 0x10
      load(4'd3, 8'h10);
      idle(4'd0, 4'd0);
      do_cycle(1, 0, 1, 0, 4'd5, 4'd0, 4'd3, 4'd0, 8'h10, 8'h00);
      chk("sub_result", result, 8'h00);
      chk("sub_flags", {V, C, N, Z}, 4'b0101);

      // Back-to-back dependency
      load(4'd1, 8'h0F);
      idle(4'd0, 4'd0);
      do_cycle(1, 1, 0, 0, 4'd1, 4'd1, 4'd1, 4'd0, 8'h00, 8'h00);
      do_cycle(1, 1, 0, 0, 4'd0, 4'd2, 4'd1, 4'd0, 8'h00, 8'h00);
      idle(4'd0, 4'd0);
      idle(4'd2, 4'd1);
`ifdef DATAPATH_BYPASS_EN
      chk("dep_r2", A_data, 8'h10);
`else
      chk("dep_r2", A_data, 8'h0F);
`endif

      // Shift right from temp bank into register 15
      load(4'd8, 8'h81);
      idle(4'd0, 4'd0);
      do_cycle(1, 1, 0, 0, 4'd13, 4'd15, 4'd0, 4'd8, 8'h00, 8'h00);
      chk("shr_result", result, 8'h40);
      chk("shr_c", C, 1'b1);
      idle(4'd0, 4'd0);
      idle(4'd15, 4'd0);
      chk("shr_r15", A_data, 8'h40);

      // Flags hold over idle cycles that request a write
      load(4'd4, 8'hFF);
      idle(4'd0, 4'd0);
      do_cycle(1, 0, 1, 0, 4'd2, 4'd0, 4'd4, 4'd0, 8'h01, 8'h00);
      chk("carry_flags", {V, C, N, Z}, 4'b0101);
      for (int i = 0; i < 3; i++) begin
         do_cycle(0, 1, 0, 1, 4'd2, 4'd4, 4'd0, 4'd0, 8'h00, 8'h33);
         chk("hold_flags", {V, C, N, Z}, 4'b0101);
         chk("hold_out_valid", out_valid, 1'b0);
      end
      idle(4'd4, 4'd0);
      chk("hold_r4", A_data, 8'hFF);

      // Random control words
      for (int i = 0; i < 400; i++) begin
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
